// File: rtl/seq_gen_if.sv
// rtl/seq_gen_if.sv - control and serial-output bundle of the sequence transmitter
interface seq_gen_if #(
    parameter int DATA_W = 4
);
    logic              start;
    logic              stop;
    logic              bit_en;
    logic [DATA_W-1:0] pattern;
    logic              ser_bit;
    logic              ser_vld;
    logic              busy;
    logic              done;
    logic [7:0]        word_cnt;

    modport master (
        output start, stop, bit_en, pattern,
        input  ser_bit, ser_vld, busy, done, word_cnt
    );

    modport slave (
        input  start, stop, bit_en, pattern,
        output ser_bit, ser_vld, busy, done, word_cnt
    );
endinterface

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - parallel-to-serial pattern transmitter, MSB first, with idle gap
// Optional SEQ_GEN_REPEAT_EN: END recaptures the pattern and keeps transmitting until stop.
module seq_gen #(
    parameter int DATA_W    = 4,
    parameter int GAP_TICKS = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_gen_if.slave bus
);
    localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam int GW = (GAP_TICKS > 2) ? $clog2(GAP_TICKS) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [BW-1:0]     bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              ser_bit_q;
    logic              ser_vld_q;
    logic              done_q;
    logic [7:0]        word_cnt_q;

    logic capture;
    logic shift;
    logic gap_tick;
    logic enter_end;
    logic enter_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // stop overrides every other event, including the END bookkeeping
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        shift     = 1'b0;
        gap_tick  = 1'b0;
        if (bus.stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        capture   = 1'b1;
                        state_nxt = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bus.bit_en) begin
                        shift = 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = (GAP_TICKS > 0) ? S_GAP : S_END;
                        end
                    end
                end
                S_GAP: begin
                    if (bus.bit_en) begin
                        gap_tick = 1'b1;
                        if (gap_cnt == GAP_LAST) begin
                            state_nxt = S_END;
                        end
                    end
                end
                S_END: begin
`ifdef SEQ_GEN_REPEAT_EN
                    capture   = 1'b1;
                    state_nxt = S_SHIFT;
`else
                    state_nxt = S_IDLE;
`endif
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign enter_end  = (state_nxt == S_END) && (state != S_END);
    assign enter_idle = (state_nxt == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            ser_bit_q  <= 1'b0;
            ser_vld_q  <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= 8'd0;
        end else begin
            ser_vld_q <= shift;
            done_q    <= enter_end;
            if (enter_end) begin
                word_cnt_q <= word_cnt_q + 8'd1;
            end

            if (capture) begin
                shift_reg <= bus.pattern;
                bit_cnt   <= '0;
            end else if (shift) begin
                shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                bit_cnt   <= bit_cnt + BW'(1);
            end

            if (shift) begin
                ser_bit_q <= shift_reg[DATA_W-1];
            end else if (enter_idle) begin
                ser_bit_q <= 1'b0;
            end

            if (state != S_GAP) begin
                gap_cnt <= '0;
            end else if (gap_tick) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

    assign bus.ser_bit  = ser_bit_q;
    assign bus.ser_vld  = ser_vld_q;
    assign bus.done     = done_q;
    assign bus.word_cnt = word_cnt_q;
    assign bus.busy     = (state != S_IDLE);
endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - directed self-checking bench for seq_gen (DATA_W=4, GAP_TICKS=2)
module tb_seq_gen;
    logic clk = 1'b0;
    logic rst_n;

    seq_gen_if #(.DATA_W(4)) bus ();

    seq_gen #(.DATA_W(4), .GAP_TICKS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // strobe generator: one-clk bit_en every bit_period clocks, off when 0
    int bit_period = 0;
    int be_cnt = 0;
    always @(negedge clk) begin
        if (bit_period == 0) begin
            bus.bit_en = 1'b0;
            be_cnt = 0;
        end else begin
            bus.bit_en = (be_cnt == 0);
            be_cnt = (be_cnt + 1) % bit_period;
        end
    end

    logic rx_q[$];
    int   done_cnt = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   done_cyc = 0;
    logic prev_busy = 1'b0;
    logic track_busy = 1'b0;
    int   busy_low = 0;
    always @(negedge clk) begin
        cyc++;
        if (bus.ser_vld) rx_q.push_back(bus.ser_bit);
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.busy && !prev_busy) rise_cyc = cyc;
        if (track_busy && !bus.busy) busy_low++;
        prev_busy = bus.busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rx_word();
        logic [31:0] w = '0;
        foreach (rx_q[i]) w = {w[30:0], rx_q[i]};
        return w;
    endfunction

    task automatic wait_done(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            tick();
        end
        check(name, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) break;
            tick();
        end
        check(name, 32'(rx_q.size() >= n), 32'd1);
    endtask

    typedef struct {
        logic [3:0] pat;
        int         period;
        logic [3:0] exp_bits;
        int         exp_lat;
    } vec_t;

    vec_t vecs[5];
    int   exp_wc = 0;
    int   d0;
    int   nonzero;

    initial begin
        vecs[0] = '{pat: 4'b1011, period: 4, exp_bits: 4'b1011, exp_lat: -1};
        vecs[1] = '{pat: 4'b0110, period: 1, exp_bits: 4'b0110, exp_lat: 6};
        vecs[2] = '{pat: 4'b1000, period: 3, exp_bits: 4'b1000, exp_lat: -1};
        vecs[3] = '{pat: 4'b0001, period: 2, exp_bits: 4'b0001, exp_lat: -1};
        vecs[4] = '{pat: 4'b1111, period: 1, exp_bits: 4'b1111, exp_lat: 6};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.pattern = 4'b0000;
        repeat (3) tick();
        rst_n = 1'b1;

        nonzero = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.ser_bit || bus.ser_vld || bus.busy || bus.done || bus.word_cnt != 8'd0) nonzero++;
        end
        check("idle_outputs_nonzero_cycles", 32'(nonzero), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_word_cnt", 32'(bus.word_cnt), 32'd0);

`ifdef SEQ_GEN_REPEAT_EN
        bit_period = 1;
        bus.pattern = 4'b0110;
        rx_q.delete();
        d0 = done_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        track_busy = 1'b1;
        wait_done(d0 + 300, 5000, "repeat_done_timeout");
        check("repeat_done_count", 32'(done_cnt - d0), 32'd300);
        check("repeat_word_cnt", 32'(bus.word_cnt), 32'd44);
        check("repeat_busy_low", 32'(busy_low), 32'd0);
        check("repeat_rx_bits", 32'(rx_q.size()), 32'd1200);
        if (rx_q.size() >= 8) begin
            logic [7:0] first8;
            first8 = '0;
            for (int i = 0; i < 8; i++) first8 = {first8[6:0], rx_q[i]};
            check("repeat_first_words", 32'(first8), 32'h66);
        end
        bus.stop = 1'b1;
        tick();
        track_busy = 1'b0;
        bus.stop = 1'b0;
        check("repeat_stop_busy", 32'(bus.busy), 32'd0);
        check("repeat_stop_ser_bit", 32'(bus.ser_bit), 32'd0);
`else
        for (int v = 0; v < 5; v++) begin
            rx_q.delete();
            bit_period = vecs[v].period;
            bus.pattern = vecs[v].pat;
            d0 = done_cnt;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            wait_done(d0 + 1, 200, $sformatf("vec%0d_done_timeout", v));
            exp_wc++;
            check($sformatf("vec%0d_word_cnt", v), 32'(bus.word_cnt), 32'(exp_wc));
            check($sformatf("vec%0d_busy_in_end", v), 32'(bus.busy), 32'd1);
            tick();
            check($sformatf("vec%0d_busy_after", v), 32'(bus.busy), 32'd0);
            check($sformatf("vec%0d_ser_bit_idle", v), 32'(bus.ser_bit), 32'd0);
            tick();
            check($sformatf("vec%0d_done_pulses", v), 32'(done_cnt - d0), 32'd1);
            check($sformatf("vec%0d_bit_count", v), 32'(rx_q.size()), 32'd4);
            check($sformatf("vec%0d_bits", v), rx_word(), 32'(vecs[v].exp_bits));
            if (vecs[v].exp_lat >= 0)
                check($sformatf("vec%0d_latency", v), 32'(done_cyc - rise_cyc), 32'(vecs[v].exp_lat));
        end

        // start held high, pattern changed mid-word
        rx_q.delete();
        bit_period = 2;
        bus.pattern = 4'b1011;
        d0 = done_cnt;
        bus.start = 1'b1;
        wait_rx(2, 200, "held_rx2_timeout");
        bus.pattern = 4'b0000;
        wait_done(d0 + 1, 200, "held_done1_timeout");
        wait_done(d0 + 2, 200, "held_done2_timeout");
        bus.start = 1'b0;
        exp_wc += 2;
        check("held_word_cnt", 32'(bus.word_cnt), 32'(exp_wc));
        repeat (3) tick();
        check("held_busy_after", 32'(bus.busy), 32'd0);
        check("held_done_pulses", 32'(done_cnt - d0), 32'd2);
        check("held_bit_count", 32'(rx_q.size()), 32'd8);
        check("held_bits", rx_word(), 32'hB0);

        // stop after the second bit
        rx_q.delete();
        bit_period = 3;
        bus.pattern = 4'b1111;
        d0 = done_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_rx(2, 200, "stop_rx2_timeout");
        check("stop_ser_bit_before", 32'(bus.ser_bit), 32'd1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stop_busy", 32'(bus.busy), 32'd0);
        check("stop_ser_bit", 32'(bus.ser_bit), 32'd0);
        check("stop_ser_vld", 32'(bus.ser_vld), 32'd0);
        repeat (20) tick();
        check("stop_word_cnt", 32'(bus.word_cnt), 32'(exp_wc));
        check("stop_no_done", 32'(done_cnt - d0), 32'd0);
        check("stop_bit_count", 32'(rx_q.size()), 32'd2);

        bus.stop = 1'b1;
        bus.start = 1'b1;
        repeat (3) tick();
        check("stop_start_busy", 32'(bus.busy), 32'd0);
        bus.stop = 1'b0;
        bus.start = 1'b0;

        // asynchronous reset after the third bit
        rx_q.delete();
        bit_period = 2;
        bus.pattern = 4'b1011;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_rx(3, 200, "rst_rx3_timeout");
        check("rst_ser_bit_before", 32'(bus.ser_bit), 32'd1);
        check("rst_word_cnt_before", 32'(bus.word_cnt), 32'(exp_wc));
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              32'({bus.busy, bus.ser_bit, bus.ser_vld, bus.done, bus.word_cnt}), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("rst_busy_after", 32'(bus.busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
